seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector. It is the programmable successor of the fixed "1001" detector FSM. The pattern, its length (1..PAT_W) and overlap mode are loaded at runtime. The block has a valid-qualified serial input, a registered one-cycle match pulse and a saturating match counter. It sits after a bit-serial receiver and flags framing and sync words for downstream control logic.

---
 rtl/seq_pattern_detector.sv | 104 ++++++++++
 tb/tb_seq_pattern_detector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector: valid-qualified bit stream in,
// registered one-cycle match pulse and saturating match counter out.
module seq_pattern_detector #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'h09),
    parameter int               DEF_LEN = 4,
    parameter bit               DEF_OVL = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic             armed
);

    localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] next_hist;
    logic [PAT_W-1:0] lenmask;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] next_fill;
    logic [LEN_W-1:0] len_clamped;
    logic             ovl;
    logic             eq;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    // Post-shift view, so the completing bit takes part in the compare.
    always_comb begin
        next_hist = in_valid ? {hist[PAT_W-2:0], in_bit} : hist;
        next_fill = (in_valid && fill != FULL) ? fill + 1'b1 : fill;
        lenmask   = '0;
        for (int i = 0; i < PAT_W; i++) begin
            lenmask[i] = (i < int'(len));
        end
        eq = in_valid && !cfg_load && (next_fill >= len) &&
             (((next_hist ^ pattern) & lenmask) == '0);
        len_clamped = (cfg_len == '0 || cfg_len > FULL) ? FULL : cfg_len;
    end

    // A clear coinciding with a match restarts the count at one.
    always_comb begin
        cnt_next = match_count;
        if (cnt_clr) begin
            cnt_next = eq ? CNT_W'(1) : '0;
        end else if (eq && match_count != CNT_MAX) begin
            cnt_next = match_count + 1'b1;
        end
        sat_next = cnt_clr ? (cnt_next == CNT_MAX)
                           : (cnt_sat || cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern     <= DEF_PAT;
            len         <= LEN_W'(DEF_LEN);
            ovl         <= DEF_OVL;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            cnt_sat     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            match_count <= cnt_next;
            cnt_sat     <= sat_next;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= len_clamped;
                ovl     <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
                match   <= 1'b0;
                armed   <= 1'b0;
            end else begin
                hist  <= next_hist;
                match <= eq;
                // Non-overlap mode demands len fresh bits after every hit.
                if (eq && !ovl) begin
                    fill  <= '0;
                    armed <= 1'b0;
                end else begin
                    fill  <= next_fill;
                    armed <= (next_fill >= len);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed vector table, reset sequences and
// randomized traffic against a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic             in_valid;
    logic             in_bit;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             cnt_sat;
    logic             armed;

    int vectors     = 0;
    int miscompares = 0;

    seq_pattern_detector #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .cnt_sat     (cnt_sat),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] p;
        logic [3:0] l;
        logic       o;
        logic       v;
        logic       b;
        logic       c;
        logic       em;
        logic [2:0] ec;
        logic       es;
        logic       ea;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the valid bits seen since the last restart, newest last.
    bit         q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_match;
    bit         m_sat;
    bit         m_armed;
    int         m_cnt;

    function automatic void model_reset();
        q.delete();
        m_pat = 8'h09; m_len = 4; m_ovl = 1'b1;
        m_match = 1'b0; m_sat = 1'b0; m_armed = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic ld, input logic [7:0] p, input logic [3:0] l,
                                       input logic o, input logic v, input logic b, input logic c);
        bit hit = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = (l == 0 || l > PAT_W) ? PAT_W : int'(l);
            m_ovl = o;
            q.delete();
        end else if (v) begin
            q.push_back(b);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() >= m_len) begin
                hit = 1'b1;
                for (int j = 0; j < m_len; j++)
                    if (q[q.size() - 1 - j] != m_pat[j]) hit = 1'b0;
            end
            if (hit && !m_ovl) q.delete();
        end
        m_match = hit;
        if (c) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < MAXC) m_cnt++;
        m_sat   = c ? (m_cnt == MAXC) : (m_sat || m_cnt == MAXC);
        m_armed = (q.size() >= m_len);
    endfunction

    function automatic void add(input logic ld, input logic [7:0] p, input logic [3:0] l, input logic o,
                                input logic v, input logic b, input logic c,
                                input logic em, input logic [2:0] ec, input logic es, input logic ea);
        vec_t t;
        t.ld = ld; t.p = p; t.l = l; t.o = o; t.v = v; t.b = b; t.c = c;
        t.em = em; t.ec = ec; t.es = es; t.ea = ea;
        tbl.push_back(t);
    endfunction

    task automatic drive(input logic ld, input logic [7:0] p, input logic [3:0] l, input logic o,
                         input logic v, input logic b, input logic c);
        cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        in_valid = v; in_bit = b; cnt_clr = c;
        model_step(ld, p, l, o, v, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic em, input logic [2:0] ec,
                       input logic es, input logic ea);
        vectors++;
        if (match !== em) begin
            miscompares++;
            $display("FAIL %s match got %0b want %0b @%0t", nm, match, em, $time);
        end
        if (match_count !== ec) begin
            miscompares++;
            $display("FAIL %s match_count got %0d want %0d @%0t", nm, match_count, ec, $time);
        end
        if (cnt_sat !== es) begin
            miscompares++;
            $display("FAIL %s cnt_sat got %0b want %0b @%0t", nm, cnt_sat, es, $time);
        end
        if (armed !== ea) begin
            miscompares++;
            $display("FAIL %s armed got %0b want %0b @%0t", nm, armed, ea, $time);
        end
    endtask

    initial begin
        logic [7:0] pb;
        logic       rb [4];

        rst = 1'b1; cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        in_valid = 0; in_bit = 0; cnt_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();

        // Default 1001 detection, then overlapping continuation to 1001001.
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 1);
        // Same pattern, non-overlapping replay of 1001001.
        add(1, 8'h09, 4, 0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 3, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 3, 0, 0);
        // Idle gaps (in_bit toggled high while invalid) inside 1001.
        add(1, 8'h09, 4, 1, 0, 0, 0, 0, 3, 0, 0);
        rb[0] = 1; rb[1] = 0; rb[2] = 0; rb[3] = 1;
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 0, 0, 1, rb[k], 0, k == 3, k == 3 ? 3'd4 : 3'd3, 0, k == 3);
            for (int g = 0; g < 3; g++)
                add(0, 0, 0, 0, 0, 1, 0, 0, k == 3 ? 3'd4 : 3'd3, 0, k == 3);
        end
        // Load 0xB5/8 with a bit on the load edge, which must be dropped.
        add(1, 8'hB5, 8, 1, 1, 1, 0, 0, 4, 0, 0);
        pb = 8'hB5;
        for (int k = 7; k >= 0; k--)
            add(0, 0, 0, 0, 1, pb[k], 0, k == 0, k == 0 ? 3'd5 : 3'd4, 0, k == 0);
        // len=0 is stored as 8: pattern 0x81 needs all eight bits.
        add(1, 8'h81, 0, 1, 0, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 5, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 6, 0, 1);
        // Saturation with the 1-bit pattern '1', then clear on a matching edge.
        add(1, 8'h01, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            add(0, 0, 0, 0, 1, 1, 0, 1, 3'((k > MAXC) ? MAXC : k), k >= MAXC, 1);
        add(0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].ld, tbl[i].p, tbl[i].l, tbl[i].o, tbl[i].v, tbl[i].b, tbl[i].c);
            chk($sformatf("vec%0d", i), tbl[i].em, tbl[i].ec, tbl[i].es, tbl[i].ea);
        end

        // Async reset after a partial 1,0,0: outputs clear without a clock edge.
        drive(1, 8'h09, 4, 1, 0, 0, 0); chk("rs_load", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);     chk("rs_b1", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);     chk("rs_b2", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);     chk("rs_b3", 0, 1, 0, 0);
        in_valid = 0;
        #1 rst = 1'b1;
        #1 chk("rst_async", 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 1, 1, 0); chk("post_rst_1", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0); chk("post_rst_2", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0); chk("post_rst_3", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0); chk("post_rst_4", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1, 0); chk("post_rst_5", 1, 1, 0, 1);
        // Reset while the match pulse is high must kill it.
        in_valid = 0;
        #1 rst = 1'b1;
        #1 chk("rst_kill", 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            logic       ld, v, b, c, o;
            logic [7:0] p;
            logic [3:0] l;
            ld = ($urandom_range(0, 39) == 0);
            p  = 8'($urandom);
            l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            o  = 1'($urandom);
            v  = ($urandom_range(0, 9) < 7);
            b  = 1'($urandom);
            c  = ($urandom_range(0, 49) == 0);
            drive(ld, p, l, o, v, b, c);
            chk("rand", m_match, 3'(m_cnt), m_sat, m_armed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
